// File: rtl/mod_data_mem_responder.sv
// Data-memory responder with optional wait-state stall (DMEM_WAIT_STATES_EN);
// without the macro it behaves as a zero-latency memory and hold stays low.
`timescale 1ns/1ps
module mod_data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_address,
  input  logic [31:0] write_data,
  output logic [31:0] data_out,
  output logic        hold,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Out-of-range parameters leave a marker block in the elaborated hierarchy.
  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_illegal_wait_states
  end
  if (DEPTH_WORDS < 16 || DEPTH_WORDS > 4096) begin : g_illegal_depth
  end

  logic [31:0]   mem [DEPTH_WORDS];
  logic          req;
  logic [AW-1:0] live_idx;
  logic          live_bad;
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  assign req      = mem_read | mem_write;
  assign live_idx = data_address[AW+1:2];
  assign live_bad = (data_address[1:0] != 2'b00) || (data_address[31:AW+2] != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

`ifdef DMEM_WAIT_STATES_EN
  // state  | meaning
  // S_IDLE | no access; hold follows req, request latched on acceptance
  // S_WAIT | stalling, cnt counts remaining wait cycles down to 1
  // S_DONE | hold low; read data driven, write committed at exit edge
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_data;
  logic          lat_write;
  logic          lat_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      lat_bad   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          lat_idx   <= live_idx;
          lat_data  <= write_data;
          lat_write <= mem_write;
          lat_bad   <= live_bad;
          cnt       <= CNT_LOAD;
          state     <= (WAIT_STATES == 1) ? S_DONE : S_WAIT;
          if (live_bad || (mem_read && mem_write)) err <= 1'b1;
        end
        S_WAIT: begin
          if (!req)            state <= S_IDLE;
          else if (cnt == 4'd1) state <= S_DONE;
          else                 cnt   <= cnt - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_we    = (state == S_DONE) && req && lat_write && !lat_bad;
  assign mem_widx  = lat_idx;
  assign mem_wdata = lat_data;

  always_comb begin
    hold     = 1'b0;
    data_out = '0;
    case (state)
      S_IDLE: hold = req & reset;
      S_WAIT: hold = reset;
      S_DONE: if (!lat_write && !lat_bad) data_out = mem[lat_idx];
      default: hold = 1'b0;
    endcase
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          err <= 1'b0;
    else if (req && (live_bad || (mem_read && mem_write))) err <= 1'b1;
  end

  assign hold      = 1'b0;
  assign mem_we    = mem_write && !live_bad;
  assign mem_widx  = live_idx;
  assign mem_wdata = write_data;
  assign data_out  = (mem_read && !mem_write && !live_bad) ? mem[live_idx] : '0;
`endif

endmodule

// File: tb/tb_mod_data_mem_responder.sv
// Directed bench for mod_data_mem_responder at WAIT_STATES 2, 1 and 15;
// expectations follow whether DMEM_WAIT_STATES_EN is defined.
`timescale 1ns/1ps
module tb_mod_data_mem_responder;

`ifdef DMEM_WAIT_STATES_EN
  localparam int HW2 = 2;
  localparam int HW1 = 1;
  localparam int HW15 = 15;
`else
  localparam int HW2 = 0;
  localparam int HW1 = 0;
  localparam int HW15 = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0, rd15 = 0, wr15 = 0;
  logic [31:0] dout0, dout1, dout15;
  logic hold0, hold1, hold15, err0, err1, err15;
  logic hold_seen = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (hold0 || hold1 || hold15) hold_seen <= 1'b1;

  mod_data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0), .data_address(addr),
    .write_data(wdata), .data_out(dout0), .hold(hold0), .err(err0));
  mod_data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .mem_read(rd1), .mem_write(wr1), .data_address(addr),
    .write_data(wdata), .data_out(dout1), .hold(hold1), .err(err1));
  mod_data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(15)) u_ws15 (
    .clk(clk), .reset(reset), .mem_read(rd15), .mem_write(wr15), .data_address(addr),
    .write_data(wdata), .data_out(dout15), .hold(hold15), .err(err15));

  task automatic set_req(input int inst, input logic r, input logic w);
    case (inst)
      1:       begin rd1 = r;  wr1 = w;  end
      15:      begin rd15 = r; wr15 = w; end
      default: begin rd0 = r;  wr0 = w;  end
    endcase
  endtask

  function automatic logic get_hold(input int inst);
    case (inst)
      1:       return hold1;
      15:      return hold15;
      default: return hold0;
    endcase
  endfunction

  function automatic logic [31:0] get_dout(input int inst);
    case (inst)
      1:       return dout1;
      15:      return dout15;
      default: return dout0;
    endcase
  endfunction

  // Holds the request until the DONE cycle has passed; reports hold width,
  // data seen in the DONE cycle and whether data_out was nonzero while stalled.
  task automatic access(input int inst, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int hc, output logic [31:0] dd,
                        output logic leak);
    hc = 0;
    leak = 1'b0;
    addr = a;
    wdata = d;
    set_req(inst, r, w);
    #1;
    while (get_hold(inst) && hc < 40) begin
      hc++;
      if (get_dout(inst) !== 32'h0) leak = 1'b1;
      @(posedge clk); #1;
    end
    dd = get_dout(inst);
    @(posedge clk); #1;
    set_req(inst, 1'b0, 1'b0);
    #1;
  endtask

  task automatic test_reset;
    n_cmp++; if (hold0 !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b want 0", hold0); end
    n_cmp++; if (dout0 !== 32'h0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", dout0); end
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err0); end
  endtask

  task automatic test_write_read;
    int hc; logic [31:0] dd; logic lk;
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, hc, dd, lk);
    n_cmp++; if (hc !== HW2) begin n_bad++; $display("FAIL write_hold_width: got %0d want %0d", hc, HW2); end
    n_cmp++; if (dd !== 32'h0) begin n_bad++; $display("FAIL write_done_dout: got %h want 0", dd); end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, hc, dd, lk);
    n_cmp++; if (hc !== HW2) begin n_bad++; $display("FAIL read_hold_width: got %0d want %0d", hc, HW2); end
    n_cmp++; if (dd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_done_data: got %h want deadbeef", dd); end
    n_cmp++; if (lk !== 1'b0) begin n_bad++; $display("FAIL read_dout_during_hold: got %b want 0", lk); end
    n_cmp++; if (dout0 !== 32'h0) begin n_bad++; $display("FAIL read_idle_dout: got %h want 0", dout0); end
  endtask

  task automatic test_wait_widths;
    int hc; logic [31:0] dd; logic lk;
    access(1, 1'b0, 1'b1, 32'h20, 32'hA5A50001, hc, dd, lk);
    n_cmp++; if (hc !== HW1) begin n_bad++; $display("FAIL ws1_write_width: got %0d want %0d", hc, HW1); end
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, hc, dd, lk);
    n_cmp++; if (hc !== HW1) begin n_bad++; $display("FAIL ws1_read_width: got %0d want %0d", hc, HW1); end
    n_cmp++; if (dd !== 32'hA5A50001) begin n_bad++; $display("FAIL ws1_read_data: got %h want a5a50001", dd); end
    access(15, 1'b0, 1'b1, 32'h20, 32'h0F0F1515, hc, dd, lk);
    n_cmp++; if (hc !== HW15) begin n_bad++; $display("FAIL ws15_write_width: got %0d want %0d", hc, HW15); end
    access(15, 1'b1, 1'b0, 32'h20, 32'h0, hc, dd, lk);
    n_cmp++; if (hc !== HW15) begin n_bad++; $display("FAIL ws15_read_width: got %0d want %0d", hc, HW15); end
    n_cmp++; if (dd !== 32'h0F0F1515) begin n_bad++; $display("FAIL ws15_read_data: got %h want 0f0f1515", dd); end
    n_cmp++; if (lk !== 1'b0) begin n_bad++; $display("FAIL ws15_dout_during_hold: got %b want 0", lk); end
    n_cmp++; if ({err1, err15} !== 2'b00) begin n_bad++; $display("FAIL ws_err: got %b want 00", {err1, err15}); end
  endtask

  task automatic test_abort;
    int hc; logic [31:0] dd; logic lk;
`ifdef DMEM_WAIT_STATES_EN
    addr = 32'h30; wdata = 32'h12345678; wr0 = 1'b1;
    @(posedge clk); #1;
    addr = 32'h0; wdata = 32'h0; wr0 = 1'b0;
    #1;
    n_cmp++; if (hold0 !== 1'b1) begin n_bad++; $display("FAIL abort_wait_hold: got %b want 1", hold0); end
    @(posedge clk); #1;
    n_cmp++; if (hold0 !== 1'b0) begin n_bad++; $display("FAIL abort_idle_hold: got %b want 0", hold0); end
`endif
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, hc, dd, lk);
    n_cmp++; if (dd !== 32'h0) begin n_bad++; $display("FAIL abort_word12: got %h want 0", dd); end
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL abort_err: got %b want 0", err0); end
  endtask

  task automatic test_err;
    int hc; logic [31:0] dd; logic lk;
    access(0, 1'b0, 1'b1, 32'h31, 32'h11111111, hc, dd, lk);
    n_cmp++; if (hc !== HW2) begin n_bad++; $display("FAIL misalign_width: got %0d want %0d", hc, HW2); end
    n_cmp++; if (err0 !== 1'b1) begin n_bad++; $display("FAIL misalign_err: got %b want 1", err0); end
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, hc, dd, lk);
    n_cmp++; if (dd !== 32'h0) begin n_bad++; $display("FAIL misalign_no_write: got %h want 0", dd); end
    access(0, 1'b1, 1'b1, 32'h40, 32'h22222222, hc, dd, lk);
    n_cmp++; if (dd !== 32'h0) begin n_bad++; $display("FAIL rdwr_dout: got %h want 0", dd); end
    n_cmp++; if (err0 !== 1'b1) begin n_bad++; $display("FAIL rdwr_err: got %b want 1", err0); end
    access(0, 1'b0, 1'b1, 32'h410, 32'h33333333, hc, dd, lk);
    access(0, 1'b1, 1'b0, 32'h410, 32'h0, hc, dd, lk);
    n_cmp++; if (dd !== 32'h0) begin n_bad++; $display("FAIL highbits_read: got %h want 0", dd); end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, hc, dd, lk);
    n_cmp++; if (dd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL highbits_alias: got %h want deadbeef", dd); end
    n_cmp++; if (err0 !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err0); end
  endtask

  task automatic test_reset_mid;
    int hc; logic [31:0] dd; logic lk;
    addr = 32'h50; wdata = 32'h55555555; wr0 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (hold0 !== 1'b0) begin n_bad++; $display("FAIL midreset_hold: got %b want 0", hold0); end
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL midreset_err: got %b want 0", err0); end
    wr0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    access(0, 1'b1, 1'b0, 32'h50, 32'h0, hc, dd, lk);
    n_cmp++; if (dd !== 32'h0) begin n_bad++; $display("FAIL midreset_write_lost: got %h want 0", dd); end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, hc, dd, lk);
    n_cmp++; if (dd !== 32'h0) begin n_bad++; $display("FAIL midreset_mem_cleared: got %h want 0", dd); end
  endtask

  task automatic test_back_to_back;
    int hc; logic [31:0] dd; logic lk;
    access(0, 1'b0, 1'b1, 32'h60, 32'h60606060, hc, dd, lk);
    access(0, 1'b0, 1'b1, 32'h64, 32'h64646464, hc, dd, lk);
    access(0, 1'b1, 1'b0, 32'h60, 32'h0, hc, dd, lk);
    n_cmp++; if (dd !== 32'h60606060) begin n_bad++; $display("FAIL b2b_read60: got %h want 60606060", dd); end
    n_cmp++; if (hc !== HW2) begin n_bad++; $display("FAIL b2b_width: got %0d want %0d", hc, HW2); end
    access(0, 1'b1, 1'b0, 32'h64, 32'h0, hc, dd, lk);
    n_cmp++; if (dd !== 32'h64646464) begin n_bad++; $display("FAIL b2b_read64: got %h want 64646464", dd); end
    n_cmp++; if (hold_seen !== (HW2 != 0)) begin n_bad++; $display("FAIL hold_ever_high: got %b want %b", hold_seen, (HW2 != 0)); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    test_reset();
    test_write_read();
    test_wait_widths();
    test_abort();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
